// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage of the 5-stage MIPS core. Owns the PC register,
// runs the inst-SRAM request/response handshake and loads the IF/ID pipeline
// register. A fetch whose PC is redirected while in flight is discarded when
// its word returns. A word that returns during a pipeline stall is parked in a
// hold buffer until the pipeline advances.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   NPC            next fetch address from the next-PC unit
//   PCWr           pipeline advance enable (0 = hazard stall)
//   PC_Flush       redirect: PC <= NPC, kill current fetch
//   IF_Flush       invalidate IF/ID contents
//   pre_PC         current fetch PC
//   inst_req       fetch request valid
//   inst_addr      fetch address (= pre_PC)
//   inst_addr_ok   SRAM accepted the request this cycle
//   inst_data_ok   SRAM read data valid this cycle
//   inst_rdata     SRAM read data
//   IF_ID_valid    IF/ID holds a live instruction
//   IF_ID_instr    fetched instruction
//   IF_ID_PC       address of IF_ID_instr
//   fetch_stall    no instruction deliverable this cycle
// -----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] NPC,
    input  logic        PCWr,
    input  logic        PC_Flush,
    input  logic        IF_Flush,
    output logic [31:0] pre_PC,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        IF_ID_valid,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_PC,
    output logic        fetch_stall
);

    // IDLE: post-reset gap; REQ: request on the bus; WAIT: accepted, awaiting
    // data; DROP: awaiting data that will be thrown away; HOLD: word buffered.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DROP = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] hold_buf_r;
    logic [31:0] hold_buf_next_s;
    logic        inst_req_r;
    logic        commit_s;
    logic [31:0] commit_word_s;
    logic        id_valid_r;
    logic [31:0] id_instr_r;
    logic [31:0] id_pc_r;

    // Next-state, next-PC, hold buffer and commit decode for the fetch FSM.
    always_comb begin
        state_next_s    = state_r;
        pc_next_s       = pc_r;
        hold_buf_next_s = hold_buf_r;
        commit_s        = 1'b0;
        commit_word_s   = inst_rdata;
        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_REQ;
            end
            ST_REQ: begin
                // inst_addr follows PC, so a redirect simply retargets an
                // unaccepted request; an accepted one must be dropped later.
                if (PC_Flush) begin
                    pc_next_s = NPC;
                    if (inst_addr_ok) begin
                        state_next_s = ST_DROP;
                    end else begin
                        state_next_s = ST_REQ;
                    end
                end else if (inst_addr_ok) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (inst_data_ok) begin
                    if (PC_Flush) begin
                        pc_next_s    = NPC;
                        state_next_s = ST_REQ;
                    end else if (PCWr) begin
                        commit_s     = 1'b1;
                        pc_next_s    = NPC;
                        state_next_s = ST_REQ;
                    end else begin
                        hold_buf_next_s = inst_rdata;
                        state_next_s    = ST_HOLD;
                    end
                end else if (PC_Flush) begin
                    pc_next_s    = NPC;
                    state_next_s = ST_DROP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (PC_Flush) begin
                    pc_next_s = NPC;
                end else begin
                    pc_next_s = pc_r;
                end
                if (inst_data_ok) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_DROP;
                end
            end
            ST_HOLD: begin
                commit_word_s = hold_buf_r;
                if (PC_Flush) begin
                    pc_next_s    = NPC;
                    state_next_s = ST_REQ;
                end else if (PCWr) begin
                    commit_s     = 1'b1;
                    pc_next_s    = NPC;
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Fetch FSM, PC, hold buffer and registered request flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            hold_buf_r <= 32'h0000_0000;
            inst_req_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pc_r       <= pc_next_s;
            hold_buf_r <= hold_buf_next_s;
            inst_req_r <= (state_next_s == ST_REQ);
        end
    end

    // IF/ID register: flush beats commit, an advancing pipeline without a
    // commit inserts a bubble, otherwise contents are held.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_r <= 1'b0;
            id_instr_r <= 32'h0000_0000;
            id_pc_r    <= 32'h0000_0000;
        end else if (IF_Flush) begin
            id_valid_r <= 1'b0;
        end else if (commit_s) begin
            id_valid_r <= 1'b1;
            id_instr_r <= commit_word_s;
            id_pc_r    <= pc_r;
        end else if (PCWr) begin
            id_valid_r <= 1'b0;
        end else begin
            id_valid_r <= id_valid_r;
        end
    end

    assign pre_PC      = pc_r;
    assign inst_addr   = pc_r;
    assign inst_req    = inst_req_r;
    assign IF_ID_valid = id_valid_r;
    assign IF_ID_instr = id_instr_r;
    assign IF_ID_PC    = id_pc_r;

    // A word is deliverable when it arrives in WAIT or sits in the hold
    // buffer, unless a redirect in the same cycle discards it.
    assign fetch_stall = ~(((state_r == ST_WAIT) & inst_data_ok) | (state_r == ST_HOLD))
                         | PC_Flush;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] NPC;
    logic        PCWr;
    logic        PC_Flush;
    logic        IF_Flush;
    logic [31:0] pre_PC;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        IF_ID_valid;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_PC;
    logic        fetch_stall;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk(clk), .rst(rst), .NPC(NPC), .PCWr(PCWr), .PC_Flush(PC_Flush),
        .IF_Flush(IF_Flush), .pre_PC(pre_PC), .inst_req(inst_req),
        .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .IF_ID_valid(IF_ID_valid), .IF_ID_instr(IF_ID_instr),
        .IF_ID_PC(IF_ID_PC), .fetch_stall(fetch_stall)
    );

    // Transaction-level reference: is a fetch outstanding, is it doomed,
    // is a word parked, and what does IF/ID hold.
    bit          m_started, m_pending, m_kill, m_buf_v, m_id_valid;
    logic [31:0] m_pc, m_buf, m_addr, m_id_instr, m_id_pc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit m_req();
        return m_started && !m_pending && !m_buf_v;
    endfunction

    function automatic bit m_stall();
        return !((m_pending && !m_kill && inst_data_ok) || m_buf_v) || PC_Flush;
    endfunction

    task automatic model_update();
        bit          commit;
        logic [31:0] word;
        commit = 1'b0;
        word   = 32'h0;
        if (rst) begin
            m_started = 1'b0; m_pending = 1'b0; m_kill = 1'b0; m_buf_v = 1'b0;
            m_pc = 32'hBFC0_0000; m_buf = 32'h0; m_addr = 32'h0;
            m_id_valid = 1'b0; m_id_instr = 32'h0; m_id_pc = 32'h0;
        end else begin
            if (!m_started) begin
                m_started = 1'b1;
            end else begin
                if (m_pending) begin
                    if (inst_data_ok) begin
                        m_pending = 1'b0;
                        if (!m_kill && !PC_Flush) begin
                            if (PCWr) begin
                                commit = 1'b1; word = inst_rdata;
                            end else begin
                                m_buf_v = 1'b1; m_buf = inst_rdata;
                            end
                        end
                    end else if (PC_Flush) begin
                        m_kill = 1'b1;
                    end
                end else if (m_buf_v) begin
                    if (PC_Flush) begin
                        m_buf_v = 1'b0;
                    end else if (PCWr) begin
                        commit = 1'b1; word = m_buf; m_buf_v = 1'b0;
                    end
                end else if (inst_addr_ok) begin
                    m_pending = 1'b1; m_kill = PC_Flush; m_addr = m_pc;
                end
            end
            if (IF_Flush) begin
                m_id_valid = 1'b0;
            end else if (commit) begin
                m_id_valid = 1'b1; m_id_instr = word; m_id_pc = m_pc;
            end else if (PCWr) begin
                m_id_valid = 1'b0;
            end
            if (m_started && (PC_Flush || commit)) m_pc = NPC;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        rst = 1'b0; PCWr = 1'b1; PC_Flush = 1'b0; IF_Flush = 1'b0;
        NPC = m_pc + 32'd4; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        inst_rdata = 32'h0;
    endtask

    task automatic test_reset();
        set_idle(); rst = 1'b1;
        tick();
        set_idle(); #1;
        n_cmp++; if (pre_PC !== 32'hBFC0_0000) begin n_bad++; $display("FAIL reset_pc got=%h exp=bfc00000", pre_PC); end
        n_cmp++; if (IF_ID_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", IF_ID_valid); end
        n_cmp++; if (inst_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b exp=0", inst_req); end
        n_cmp++; if (fetch_stall !== 1'b1) begin n_bad++; $display("FAIL reset_stall got=%b exp=1", fetch_stall); end
        tick();
        n_cmp++; if (inst_req !== 1'b1) begin n_bad++; $display("FAIL reset_first_req got=%b exp=1", inst_req); end
        n_cmp++; if (inst_addr !== 32'hBFC0_0000) begin n_bad++; $display("FAIL reset_first_addr got=%h exp=bfc00000", inst_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] a;
        for (int k = 0; k < 4; k++) begin
            a = 32'hBFC0_0000 + 32'(4 * k);
            set_idle(); inst_addr_ok = 1'b1; #1;
            n_cmp++; if (inst_req !== 1'b1 || inst_addr !== a) begin n_bad++; $display("FAIL stream_req got=%b/%h exp=1/%h", inst_req, inst_addr, a); end
            tick();
            n_cmp++; if (IF_ID_valid !== 1'b0) begin n_bad++; $display("FAIL stream_bubble got=%b exp=0", IF_ID_valid); end
            set_idle(); inst_data_ok = 1'b1; inst_rdata = word_of(a); #1;
            n_cmp++; if (fetch_stall !== 1'b0) begin n_bad++; $display("FAIL stream_stall got=%b exp=0", fetch_stall); end
            tick();
            n_cmp++;
            if (IF_ID_valid !== 1'b1 || IF_ID_PC !== a || IF_ID_instr !== word_of(a)) begin
                n_bad++;
                $display("FAIL stream_commit got=%b/%h/%h exp=1/%h/%h", IF_ID_valid, IF_ID_PC, IF_ID_instr, a, word_of(a));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        a = 32'hBFC0_0010;
        set_idle(); PCWr = 1'b0; inst_addr_ok = 1'b1; tick();
        set_idle(); PCWr = 1'b0; inst_data_ok = 1'b1; inst_rdata = word_of(a); tick();
        for (int k = 0; k < 3; k++) begin
            set_idle(); PCWr = 1'b0; #1;
            n_cmp++; if (inst_req !== 1'b0 || fetch_stall !== 1'b0) begin n_bad++; $display("FAIL stall_hold got=%b/%b exp=0/0", inst_req, fetch_stall); end
            n_cmp++; if (IF_ID_valid !== 1'b1 || IF_ID_PC !== 32'hBFC0_000C) begin n_bad++; $display("FAIL stall_ifid got=%b/%h exp=1/bfc0000c", IF_ID_valid, IF_ID_PC); end
            tick();
        end
        set_idle(); tick();
        n_cmp++;
        if (IF_ID_valid !== 1'b1 || IF_ID_PC !== a || IF_ID_instr !== word_of(a)) begin
            n_bad++;
            $display("FAIL stall_release got=%b/%h/%h exp=1/%h/%h", IF_ID_valid, IF_ID_PC, IF_ID_instr, a, word_of(a));
        end
        n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0014) begin n_bad++; $display("FAIL stall_next got=%b/%h exp=1/bfc00014", inst_req, inst_addr); end
    endtask

    task automatic test_branch_redirect();
        set_idle(); inst_addr_ok = 1'b1; tick();
        set_idle(); PC_Flush = 1'b1; IF_Flush = 1'b1; NPC = 32'hBFC0_0100; #1;
        n_cmp++; if (fetch_stall !== 1'b1) begin n_bad++; $display("FAIL branch_stall got=%b exp=1", fetch_stall); end
        tick();
        n_cmp++; if (IF_ID_valid !== 1'b0 || inst_req !== 1'b0) begin n_bad++; $display("FAIL branch_drop got=%b/%b exp=0/0", IF_ID_valid, inst_req); end
        set_idle(); tick();
        set_idle(); inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF; tick();
        n_cmp++;
        if (IF_ID_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0100) begin
            n_bad++;
            $display("FAIL branch_target got=%b/%b/%h exp=0/1/bfc00100", IF_ID_valid, inst_req, inst_addr);
        end
    endtask

    task automatic test_exception();
        set_idle(); inst_addr_ok = 1'b1; tick();
        set_idle(); inst_data_ok = 1'b1; inst_rdata = word_of(32'hBFC0_0100);
        PC_Flush = 1'b1; NPC = 32'hBFC0_0380; #1;
        n_cmp++; if (fetch_stall !== 1'b1) begin n_bad++; $display("FAIL exc_stall got=%b exp=1", fetch_stall); end
        tick();
        n_cmp++;
        if (IF_ID_valid !== 1'b0 || IF_ID_PC !== 32'hBFC0_0010 || inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0380) begin
            n_bad++;
            $display("FAIL exc_redirect got=%b/%h/%b/%h exp=0/bfc00010/1/bfc00380", IF_ID_valid, IF_ID_PC, inst_req, inst_addr);
        end
    endtask

    task automatic test_reset_mid_wait();
        set_idle(); inst_addr_ok = 1'b1; tick();
        set_idle(); rst = 1'b1; tick();
        set_idle(); #1;
        n_cmp++;
        if (pre_PC !== 32'hBFC0_0000 || inst_req !== 1'b0 || fetch_stall !== 1'b1) begin
            n_bad++;
            $display("FAIL rstwait_ctl got=%h/%b/%b exp=bfc00000/0/1", pre_PC, inst_req, fetch_stall);
        end
        n_cmp++;
        if (IF_ID_valid !== 1'b0 || IF_ID_instr !== 32'h0 || IF_ID_PC !== 32'h0) begin
            n_bad++;
            $display("FAIL rstwait_ifid got=%b/%h/%h exp=0/0/0", IF_ID_valid, IF_ID_instr, IF_ID_PC);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            PCWr         = ($urandom_range(0, 3) != 0);
            PC_Flush     = ($urandom_range(0, 9) == 0);
            IF_Flush     = PC_Flush ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            NPC          = PC_Flush ? 32'($urandom) : m_pc + 32'd4;
            inst_addr_ok = m_req() && ($urandom_range(0, 1) == 1);
            inst_data_ok = m_pending && ($urandom_range(0, 2) != 0);
            inst_rdata   = inst_data_ok ? word_of(m_addr) : 32'($urandom);
            #1;
            n_cmp++; if (pre_PC !== m_pc) begin n_bad++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", c, pre_PC, m_pc); end
            n_cmp++; if (inst_addr !== m_pc) begin n_bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, inst_addr, m_pc); end
            n_cmp++; if (inst_req !== m_req()) begin n_bad++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", c, inst_req, m_req()); end
            n_cmp++; if (fetch_stall !== m_stall()) begin n_bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, fetch_stall, m_stall()); end
            n_cmp++; if (IF_ID_valid !== m_id_valid) begin n_bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, IF_ID_valid, m_id_valid); end
            n_cmp++; if (IF_ID_instr !== m_id_instr) begin n_bad++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", c, IF_ID_instr, m_id_instr); end
            n_cmp++; if (IF_ID_PC !== m_id_pc) begin n_bad++; $display("FAIL rnd_idpc cyc=%0d got=%h exp=%h", c, IF_ID_PC, m_id_pc); end
            tick();
        end
    endtask

    initial begin
        m_pc = 32'hBFC0_0000;
        set_idle();
        rst = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_branch_redirect();
        test_exception();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
